mux_select_arbiter: RTL and testbench
=====================================

Name: mux_select_arbiter

Overview:
Shares one Avalon-MM 1-bit mux-select PIO between N_REQ requesters, each needing the mux in a specific position.
- Round-robin arbitration picks one requester.
- If the required select differs from the current one, the block issues a set/clear write to the PIO and waits a settle interval before granting.
- Sits between the datapath clients and the PIO slave, as the PIO's only Avalon master.

Parameters:
N_REQ, 2, number of requesters (2..8)
SETTLE_CYCLES, 4, cycles between select write and grant (0 = grant immediately after write)
MAX_RETRY, 2, readback-mismatch rewrite attempts (used only with readback feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request, held high for the whole use of the mux
want_sel  in  N_REQ  per-requester required select value, valid while req high
gnt  out  N_REQ  one-hot registered grant
cur_sel  out  1  shadow of the PIO select value
busy  out  1  high in any state except IDLE
error  out  1  sticky readback mismatch flag (tied 0 without feature)
avm_address  out  3  PIO register address
avm_chipselect  out  1  PIO chipselect
avm_write_n  out  1  PIO write strobe, active low
avm_writedata  out  32  PIO write data
avm_readdata  in  32  PIO read data, combinational, zero wait states

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state=IDLE, gnt=0, cur_sel=0 (matches PIO reset value), error=0, rr pointer=0.
  - avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
- Bus defaults outside WRITE/READ: chipselect=0, write_n=1, address=0, writedata=0.
- IDLE:
  - If any req is high, latch winner idx by round-robin: the first set req at or after (last_idx+1) mod N_REQ.
  - Latch target=want_sel[idx].
  - target==cur_sel -> GRANT; otherwise -> WRITE.
- WRITE (exactly 1 cycle):
  - chipselect=1, write_n=0, writedata=32'h1.
  - address=4 (bit-set) if target=1, address=5 (bit-clear) if target=0.
  - cur_sel<=target.
  - Next state READ (feature) or SETTLE; SETTLE is skipped when SETTLE_CYCLES=0.
- SETTLE:
  - Counter loads SETTLE_CYCLES-1 on entry and decrements each cycle.
  - Exactly SETTLE_CYCLES cycles are spent here, then -> GRANT.
- GRANT:
  - gnt[idx]=1; the requester may use the mux.
  - When req[idx] is sampled low: gnt=0 next cycle, last_idx<=idx, -> IDLE.
- Latency:
  - Matching select: req sampled at edge 1 -> gnt high from cycle 1.
  - Mismatch: write strobe in cycle 1, gnt high from cycle 2+SETTLE_CYCLES.
  - Minimum one IDLE cycle between consecutive grants.
- Boundary conditions:
  - req[idx] dropped during WRITE/SETTLE/READ: sequence completes (cur_sel updated), no grant issued, last_idx<=idx, -> IDLE.
  - want_sel change while granted: ignored until next arbitration.
  - Simultaneous requests: exactly one winner; non-winners wait, no starvation (each waits at most N_REQ-1 grants).
  - Reset mid-sequence: all outputs return to reset values next cycle.
    - cur_sel returns to 0 regardless of the PIO.
    - The PIO and the block share the reset domain, so the two stay consistent.
- gnt is never more than one-hot.
- gnt is never high while chipselect is high.

Optional Feature:
MUXSEL_READBACK_EN:
- Defined:
  - After WRITE, READ state for 1 cycle: chipselect=1, write_n=1, address=0.
  - Sample avm_readdata[0] at end of cycle.
  - Match -> SETTLE/GRANT.
  - Mismatch -> error<=1 (sticky until reset) and rewrite via WRITE, up to MAX_RETRY times.
  - After the final mismatch, proceed to SETTLE/GRANT with error held high.
- Undefined: no READ state, error tied 0, avm_readdata unused.

Decomposition:
Package mux_sel_pkg:
- State enum (IDLE, WRITE, READ, SETTLE, GRANT).
- Address constants MUXSEL_ADDR_DATA=0, MUXSEL_ADDR_SET=4, MUXSEL_ADDR_CLR=5.
- Constant MUXSEL_WDATA_BIT=32'h1.

Sub-module mux_sel_rr_pick:
- Combinational round-robin picker.
- Inputs: req vector, last_idx. Outputs: idx, valid.

Test Plan:
- Reset then req=2'b01, want_sel=0 -> gnt=01 in cycle 1, no avm write, cur_sel=0.
- req[1] with want_sel[1]=1, SETTLE_CYCLES=4 -> one write addr=4 data=1 in cycle 1, gnt=10 in cycle 6, cur_sel=1.
- req=11 held, requesters alternately release -> grants alternate 01,10,01 with one IDLE cycle between; req[0] want 0, req[1] want 1 -> clear (addr 5) / set (addr 4) writes alternate.
- req dropped during SETTLE -> no gnt pulse, busy low after settle ends, cur_sel keeps new value.
- reset asserted in SETTLE -> next cycle gnt=0, busy=0, cur_sel=0, chipselect=0.
- MUXSEL_READBACK_EN, PIO model forcing readdata[0]=0 after set -> 1+MAX_RETRY writes to addr 4, error=1, gnt still asserted after settle.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// Shared types and PIO register map for the mux-select arbiter.
package mux_sel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        SETTLE,
        GRANT
    } state_t;

    localparam logic [2:0]  MUXSEL_ADDR_DATA = 3'd0;
    localparam logic [2:0]  MUXSEL_ADDR_SET  = 3'd4;
    localparam logic [2:0]  MUXSEL_ADDR_CLR  = 3'd5;
    localparam logic [31:0] MUXSEL_WDATA_BIT = 32'h1;

endpackage

// File: rtl/mux_sel_rr_pick.sv
// Combinational round-robin picker: first set request at or after last_idx+1 (mod N_REQ).
module mux_sel_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_idx_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int pos;

    // Scan from the farthest offset down so the nearest candidate is written last.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = (int'(last_idx_i) + 1 + k) % N_REQ;
            if (req_i[pos]) begin
                idx_o   = IDX_W'(pos);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin owner of a 1-bit mux-select PIO: rewrites the select when needed, settles, then grants.
// Optional readback verification of each write is enabled with `define MUXSEL_READBACK_EN.
module mux_select_arbiter
    import mux_sel_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_RETRY     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] want_sel,
    output logic [N_REQ-1:0] gnt,
    output logic             cur_sel,
    output logic             busy,
    output logic             error,
    output logic [2:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               target_q, target_d;
    logic               cur_sel_q, cur_sel_d;
    logic               drop_q, drop_d;
    logic               wr_done;
    logic               finish;
    logic               req_ok;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               readdata_unused;

`ifdef MUXSEL_READBACK_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic               error_q, error_d;
`endif

    mux_sel_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i      (req),
        .last_idx_i (last_q),
        .idx_o      (pick_idx),
        .valid_o    (pick_valid)
    );

    // A requester that let go at any point of the select sequence gets no grant.
    assign req_ok = req[idx_q] && !drop_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        target_d  = target_q;
        cur_sel_d = cur_sel_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        wr_done   = 1'b0;
        finish    = 1'b0;
`ifdef MUXSEL_READBACK_EN
        retry_d   = retry_q;
        error_d   = error_q;
`endif
        if ((state_q == WRITE || state_q == READ || state_q == SETTLE) && !req[idx_q])
            drop_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    idx_d    = pick_idx;
                    target_d = want_sel[pick_idx];
                    drop_d   = 1'b0;
`ifdef MUXSEL_READBACK_EN
                    retry_d  = '0;
`endif
                    state_d  = (want_sel[pick_idx] == cur_sel_q) ? GRANT : WRITE;
                end
            end
            WRITE: begin
                cur_sel_d = target_q;
`ifdef MUXSEL_READBACK_EN
                state_d   = READ;
`else
                wr_done   = 1'b1;
`endif
            end
`ifdef MUXSEL_READBACK_EN
            READ: begin
                if (avm_readdata[0] != target_q) begin
                    error_d = 1'b1;
                    if (retry_q != RTY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = WRITE;
                    end else begin
                        wr_done = 1'b1;
                    end
                end else begin
                    wr_done = 1'b1;
                end
            end
`endif
            SETTLE: begin
                if (cnt_q == '0) finish = 1'b1;
                else             cnt_d  = cnt_q - 1'b1;
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    state_d = IDLE;
                    last_d  = idx_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_done) begin
            if (SETTLE_CYCLES > 0) begin
                state_d = SETTLE;
                cnt_d   = CNT_LOAD;
            end else begin
                finish  = 1'b1;
            end
        end

        if (finish) begin
            if (req_ok) begin
                state_d = GRANT;
            end else begin
                state_d = IDLE;
                last_d  = idx_q;
            end
        end
    end

    assign gnt_d = (state_d == GRANT) ? (N_REQ'(1) << idx_d) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            cur_sel_q <= 1'b0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cur_sel_q <= cur_sel_d;
            last_q    <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q    <= idx_d;
        target_q <= target_d;
        cnt_q    <= cnt_d;
        drop_q   <= drop_d;
    end

`ifdef MUXSEL_READBACK_EN
    always_ff @(posedge clk) begin
        if (reset) error_q <= 1'b0;
        else       error_q <= error_d;
    end

    always_ff @(posedge clk) begin
        retry_q <= retry_d;
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Bus strobes are decoded from the registered state, so they never overlap a grant.
    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = MUXSEL_ADDR_DATA;
        avm_writedata  = '0;
        if (state_q == WRITE) begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_writedata  = MUXSEL_WDATA_BIT;
            avm_address    = target_q ? MUXSEL_ADDR_SET : MUXSEL_ADDR_CLR;
        end
`ifdef MUXSEL_READBACK_EN
        if (state_q == READ) avm_chipselect = 1'b1;
`endif
    end

    assign readdata_unused = ^{avm_readdata, MAX_RETRY[0]};

    assign gnt     = gnt_q;
    assign cur_sel = cur_sel_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scoreboard bench for mux_select_arbiter with a behavioural PIO slave.
module tb_mux_select_arbiter;

    localparam int N = 2;
    localparam int S = 4;
    localparam int R = 2;
`ifdef MUXSEL_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    typedef struct {
        bit         is_wr;
        logic [2:0] addr;
        logic [1:0] gnt;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  want = '0;
    logic [1:0]  gnt;
    logic        cur_sel, busy, error;
    logic [2:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [31:0] avm_writedata, avm_readdata;

    logic        pio_q = 1'b0;
    logic        stuck0 = 1'b0;
    logic [1:0]  prev_gnt = '0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    bit          exp_sel = 1'b0;
    exp_t        sb[$];
    exp_t        mon_e;

    mux_select_arbiter #(
        .N_REQ         (N),
        .SETTLE_CYCLES (S),
        .MAX_RETRY     (R)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .want_sel       (want),
        .gnt            (gnt),
        .cur_sel        (cur_sel),
        .busy           (busy),
        .error          (error),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave: bit-set / bit-clear registers, readback optionally stuck at 0.
    always @(posedge clk) begin
        if (reset) pio_q <= 1'b0;
        else if (avm_chipselect && !avm_write_n) begin
            if (avm_address == 3'd4)      pio_q <= 1'b1;
            else if (avm_address == 3'd5) pio_q <= 1'b0;
        end
    end
    assign avm_readdata = {31'b0, pio_q & ~stuck0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input logic [2:0] a, input int c);
        exp_t e;
        e.is_wr = 1'b1; e.addr = a; e.gnt = '0; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic push_gnt(input logic [1:0] g, input int c);
        exp_t e;
        e.is_wr = 1'b0; e.addr = '0; e.gnt = g; e.cyc = c;
        sb.push_back(e);
    endtask

    // Arbitration at the next edge for requester `who` wanting select `want_v`.
    task automatic arb(input int who, input bit want_v);
        int e0;
        logic [1:0] g;
        e0 = cyc + 1;
        g  = (who == 0) ? 2'b01 : 2'b10;
        if (want_v == exp_sel) begin
            push_gnt(g, e0);
        end else begin
            push_wr(want_v ? 3'd4 : 3'd5, e0);
            push_gnt(g, e0 + 1 + RB + S);
            exp_sel = want_v;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (avm_chipselect && !avm_write_n) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL wr_unexpected addr=%0d with empty queue (cycle %0d)", avm_address, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_kind", 32'(1), 32'(mon_e.is_wr));
                    chk("wr_addr", 32'(avm_address), 32'(mon_e.addr));
                    chk("wr_data", avm_writedata, 32'h1);
                    chk("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL gnt_unexpected gnt=%b with empty queue (cycle %0d)", gnt, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("gnt_kind", 32'(0), 32'(mon_e.is_wr));
                    chk("gnt_value", 32'(gnt), 32'(mon_e.gnt));
                    chk("gnt_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
            chk("gnt_onehot", 32'(gnt == 2'b11), 32'(0));
            chk("gnt_vs_cs", 32'((gnt != 2'b00) && avm_chipselect), 32'(0));
            chk("cur_sel_vs_pio", 32'(cur_sel), 32'(pio_q));
        end
        prev_gnt <= gnt;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        reset = 1'b0;
        step(1);
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_cur_sel", 32'(cur_sel), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_error", 32'(error), 32'(0));
        chk("rst_cs", 32'(avm_chipselect), 32'(0));
        chk("rst_write_n", 32'(avm_write_n), 32'(1));
        chk("rst_addr", 32'(avm_address), 32'(0));
        chk("rst_wdata", avm_writedata, 32'(0));

        // Matching select: immediate grant, no bus write.
        req = 2'b01; want = 2'b00; arb(0, 1'b0);
        step(3);
        chk("t1_cur_sel", 32'(cur_sel), 32'(0));
        chk("t1_busy", 32'(busy), 32'(1));
        req = 2'b00; step(2);

        // Mismatch: set write then settle before grant.
        req = 2'b10; want = 2'b10; arb(1, 1'b1);
        step(3 + S + RB);
        chk("t2_cur_sel", 32'(cur_sel), 32'(1));
        chk("t2_gnt", 32'(gnt), 32'(2'b10));
        req = 2'b00; step(1);
        chk("t2_busy_release", 32'(busy), 32'(0));

        // Both requesting; alternate release with clear/set writes.
        req = 2'b11; want = 2'b10; arb(0, 1'b0);
        step(3 + S + RB);
        req = 2'b10; step(1);
        chk("t3_idle_gap", 32'(gnt), 32'(0));
        req = 2'b11; arb(1, 1'b1);
        step(3 + S + RB);
        req = 2'b01; step(1);
        req = 2'b11; arb(0, 1'b0);
        step(3 + S + RB);
        req = 2'b00; step(2);

        // Reset during SETTLE.
        req = 2'b10; want = 2'b10; push_wr(3'd4, cyc + 1);
        step(3 + RB);
        reset = 1'b1;
        step(1);
        chk("t5_gnt", 32'(gnt), 32'(0));
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_cur_sel", 32'(cur_sel), 32'(0));
        chk("t5_cs", 32'(avm_chipselect), 32'(0));
        req = 2'b00; reset = 1'b0; exp_sel = 1'b0;
        step(1);

        // Requester drops during SETTLE: write completes, no grant.
        req = 2'b10; want = 2'b10; push_wr(3'd4, cyc + 1); exp_sel = 1'b1;
        step(3 + RB);
        req = 2'b00;
        step(2);
        chk("t4_busy_last_settle", 32'(busy), 32'(1));
        step(1);
        chk("t4_busy_after", 32'(busy), 32'(0));
        chk("t4_cur_sel", 32'(cur_sel), 32'(1));
        chk("t4_gnt", 32'(gnt), 32'(0));

        // want_sel change while granted is ignored.
        req = 2'b01; want = 2'b01; arb(0, 1'b1);
        step(2);
        want = 2'b00;
        step(3);
        chk("t6_cur_sel", 32'(cur_sel), 32'(1));
        chk("t6_gnt", 32'(gnt), 32'(2'b01));
        req = 2'b00; step(2);

`ifdef MUXSEL_READBACK_EN
        // Readback stuck at 0: 1+R set writes, sticky error, grant still follows.
        reset = 1'b1; step(2); reset = 1'b0; exp_sel = 1'b0; step(1);
        stuck0 = 1'b1;
        req = 2'b10; want = 2'b10;
        for (int k = 0; k <= R; k++) push_wr(3'd4, cyc + 1 + 2 * k);
        push_gnt(2'b10, cyc + 1 + 2 * (R + 1) + S);
        step(2 * (R + 1) + S + 2);
        chk("t7_error", 32'(error), 32'(1));
        chk("t7_gnt", 32'(gnt), 32'(2'b10));
        req = 2'b00; step(2);
        chk("t7_error_sticky", 32'(error), 32'(1));
`endif

        for (int i = 0; i < 30 && sb.size() != 0; i++) step(1);
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
